// File: rtl/mem_test_sequencer.sv
// mem_test_sequencer: write/read-back memory tester.
// It sweeps an external address counter twice and counts read mismatches.
//
// Ports:
//   i_CLK, i_RST_N       clock, asynchronous active-low reset
//   i_START, i_ABORT     start a run (IDLE/DONE only), abort to IDLE
//   i_ADDR               address from the external accumulator
//   o_ACC_ENABLE         accumulator count enable
//   o_ACC_RST_CONTROL    accumulator synchronous clear
//   o_MEM_WE, o_MEM_RE   memory write/read strobes
//   o_MEM_ADDR           memory address (follows i_ADDR)
//   o_MEM_WDATA          write data, i_ADDR ^ p_PATTERN
//   i_MEM_RDATA          read data, one cycle after o_MEM_RE
//   o_BUSY, o_DONE       run status
//   o_PASS               done with zero mismatches
//   o_ERR_COUNT          saturating mismatch count
//   o_FIRST_ERR_ADDR     address of the first mismatch
module mem_test_sequencer #(
  parameter int p_ADDR_WIDTH = 4,
  parameter int p_DATA_WIDTH = 8,
  parameter logic [p_DATA_WIDTH-1:0] p_PATTERN = 8'hA5,
  parameter int p_ERR_WIDTH = 8
) (
  input  logic                    i_CLK,
  input  logic                    i_RST_N,
  input  logic                    i_START,
  input  logic                    i_ABORT,
  input  logic [p_ADDR_WIDTH-1:0] i_ADDR,
  output logic                    o_ACC_ENABLE,
  output logic                    o_ACC_RST_CONTROL,
  output logic                    o_MEM_WE,
  output logic                    o_MEM_RE,
  output logic [p_ADDR_WIDTH-1:0] o_MEM_ADDR,
  output logic [p_DATA_WIDTH-1:0] o_MEM_WDATA,
  input  logic [p_DATA_WIDTH-1:0] i_MEM_RDATA,
  output logic                    o_BUSY,
  output logic                    o_DONE,
  output logic                    o_PASS,
  output logic [p_ERR_WIDTH-1:0]  o_ERR_COUNT,
  output logic [p_ADDR_WIDTH-1:0] o_FIRST_ERR_ADDR
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_WRITE,
    S_READ,
    S_CHECK,
    S_DONE
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [p_DATA_WIDTH-1:0] pattern_data;
  logic                    addr_last;

  logic                    cmp_valid_q;
  logic [p_DATA_WIDTH-1:0] cmp_exp_q;
  logic [p_ADDR_WIDTH-1:0] cmp_addr_q;
  logic                    first_seen_q;
  logic [p_ERR_WIDTH-1:0]  err_cnt_q;
  logic [p_ADDR_WIDTH-1:0] first_addr_q;
  logic                    mismatch;

  assign pattern_data = p_DATA_WIDTH'(i_ADDR) ^ p_PATTERN;
  assign addr_last    = &i_ADDR;
  assign mismatch     = cmp_valid_q && (i_MEM_RDATA != cmp_exp_q);

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (i_ABORT) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE,
        S_DONE:  if (i_START) state_d = S_CLEAR;
        S_CLEAR: state_d = S_WRITE;
        S_WRITE: if (addr_last) state_d = S_READ;
        S_READ:  if (addr_last) state_d = S_CHECK;
        S_CHECK: state_d = S_DONE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    o_ACC_ENABLE      = 1'b0;
    o_ACC_RST_CONTROL = 1'b0;
    o_MEM_WE          = 1'b0;
    o_MEM_RE          = 1'b0;
    o_MEM_WDATA       = '0;
    o_BUSY            = 1'b0;
    o_DONE            = 1'b0;
    unique case (state_q)
      S_CLEAR: begin
        o_ACC_RST_CONTROL = 1'b1;
        o_BUSY            = 1'b1;
      end
      S_WRITE: begin
        o_MEM_WE     = 1'b1;
        o_ACC_ENABLE = 1'b1;
        o_MEM_WDATA  = pattern_data;
        o_BUSY       = 1'b1;
      end
      S_READ: begin
        o_MEM_RE     = 1'b1;
        o_ACC_ENABLE = 1'b1;
        o_BUSY       = 1'b1;
      end
      S_CHECK: o_BUSY = 1'b1;
      S_DONE:  o_DONE = 1'b1;
      default: ;
    endcase
  end

  // Gate the address with reset so every output is low while in reset.
  assign o_MEM_ADDR = i_RST_N ? i_ADDR : '0;

  // One-cycle compare pipeline: the read issued now returns next cycle.
  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      cmp_valid_q <= 1'b0;
      cmp_exp_q   <= '0;
      cmp_addr_q  <= '0;
    end else if (i_ABORT) begin
      cmp_valid_q <= 1'b0;
    end else begin
      cmp_valid_q <= (state_q == S_READ);
      if (state_q == S_READ) begin
        cmp_exp_q  <= pattern_data;
        cmp_addr_q <= i_ADDR;
      end
    end
  end

  // Abort freezes the error results, including an in-flight compare.
  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      err_cnt_q    <= '0;
      first_addr_q <= '0;
      first_seen_q <= 1'b0;
    end else if (!i_ABORT) begin
      if (state_q == S_CLEAR) begin
        err_cnt_q    <= '0;
        first_addr_q <= '0;
        first_seen_q <= 1'b0;
      end else if (mismatch) begin
        if (err_cnt_q != '1) begin
          err_cnt_q <= err_cnt_q + 1'b1;
        end
        if (!first_seen_q) begin
          first_addr_q <= cmp_addr_q;
          first_seen_q <= 1'b1;
        end
      end
    end
  end

  assign o_ERR_COUNT      = err_cnt_q;
  assign o_FIRST_ERR_ADDR = first_addr_q;
  assign o_PASS           = o_DONE && (err_cnt_q == '0);

endmodule

// File: tb/tb_mem_test_sequencer.sv
// tb_mem_test_sequencer: directed bench for mem_test_sequencer.
// Models the address accumulator and a corruptible memory.
module tb_mem_test_sequencer;

  localparam int AW = 4;
  localparam int DW = 8;

  typedef struct {
    logic          hold;
    logic          cen;
    logic [AW-1:0] a1;
    logic [AW-1:0] a2;
    logic [DW-1:0] mask;
    logic [7:0]    eerr;
    logic [AW-1:0] efirst;
    logic          epass;
  } run_vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;

  logic [AW-1:0] acc;
  logic          acc_en, acc_rst;
  logic          we, re;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  logic          busy, done, pass;
  logic [7:0]    err;
  logic [AW-1:0] first;

  logic          s_acc_en, s_acc_rst, s_we, s_re;
  logic [AW-1:0] s_mem_addr;
  logic [DW-1:0] s_wdata;
  logic [DW-1:0] s_rdata;
  logic          s_busy, s_done, s_pass;
  logic [2:0]    s_err;
  logic [AW-1:0] s_first;

  logic          corrupt_en = 1'b0;
  logic [AW-1:0] corrupt_a1 = '0;
  logic [AW-1:0] corrupt_a2 = '0;
  logic [DW-1:0] corrupt_mask = '0;
  logic [DW-1:0] mem [16];

  int vectors = 0;
  int miscompares = 0;

  run_vec_t runs [4];

  always #5 clk = ~clk;

  mem_test_sequencer #(
    .p_ADDR_WIDTH(AW), .p_DATA_WIDTH(DW),
    .p_PATTERN(8'hA5), .p_ERR_WIDTH(8)
  ) dut (
    .i_CLK(clk), .i_RST_N(rst_n),
    .i_START(start), .i_ABORT(abort),
    .i_ADDR(acc),
    .o_ACC_ENABLE(acc_en),
    .o_ACC_RST_CONTROL(acc_rst),
    .o_MEM_WE(we), .o_MEM_RE(re),
    .o_MEM_ADDR(mem_addr),
    .o_MEM_WDATA(wdata),
    .i_MEM_RDATA(rdata),
    .o_BUSY(busy), .o_DONE(done), .o_PASS(pass),
    .o_ERR_COUNT(err),
    .o_FIRST_ERR_ADDR(first)
  );

  assign s_rdata = '0;

  mem_test_sequencer #(
    .p_ADDR_WIDTH(AW), .p_DATA_WIDTH(DW),
    .p_PATTERN(8'hA5), .p_ERR_WIDTH(3)
  ) sat (
    .i_CLK(clk), .i_RST_N(rst_n),
    .i_START(start), .i_ABORT(abort),
    .i_ADDR(acc),
    .o_ACC_ENABLE(s_acc_en),
    .o_ACC_RST_CONTROL(s_acc_rst),
    .o_MEM_WE(s_we), .o_MEM_RE(s_re),
    .o_MEM_ADDR(s_mem_addr),
    .o_MEM_WDATA(s_wdata),
    .i_MEM_RDATA(s_rdata),
    .o_BUSY(s_busy), .o_DONE(s_done), .o_PASS(s_pass),
    .o_ERR_COUNT(s_err),
    .o_FIRST_ERR_ADDR(s_first)
  );

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc <= '0;
    else if (acc_rst) acc <= '0;
    else if (acc_en) acc <= acc + 1'b1;
  end

  always @(posedge clk) begin
    if (we) mem[mem_addr] <= wdata;
    if (re) begin
      if (corrupt_en && (mem_addr == corrupt_a1 ||
                         mem_addr == corrupt_a2))
        rdata <= mem[mem_addr] ^ corrupt_mask;
      else
        rdata <= mem[mem_addr];
    end
  end

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input run_vec_t v);
    logic [DW-1:0] pat;
    corrupt_en   = v.cen;
    corrupt_a1   = v.a1;
    corrupt_a2   = v.a2;
    corrupt_mask = v.mask;
    start = 1'b1;
    tick();
    if (!v.hold) start = 1'b0;
    chk("clear_busy", busy, 1);
    chk("clear_accrst", acc_rst, 1);
    chk("clear_we", we, 0);
    tick();
    chk("clr_err", err, 0);
    chk("clr_first", first, 0);
    for (int k = 0; k < 16; k++) begin
      pat = 8'(k) ^ 8'hA5;
      chk("wr_we", we, 1);
      chk("wr_re", re, 0);
      chk("wr_acc_en", acc_en, 1);
      chk("wr_addr", mem_addr, k);
      chk("wr_data", wdata, pat);
      tick();
    end
    start = 1'b0;
    for (int k = 0; k < 16; k++) begin
      chk("rd_re", re, 1);
      chk("rd_we", we, 0);
      chk("rd_acc_en", acc_en, 1);
      chk("rd_addr", mem_addr, k);
      chk("rd_wdata", wdata, 0);
      tick();
    end
    chk("chk_busy", busy, 1);
    chk("chk_re", re, 0);
    chk("chk_done", done, 0);
    tick();
    chk("done", done, 1);
    chk("done_busy", busy, 0);
    chk("done_acc_en", acc_en, 0);
    chk("pass", pass, v.epass);
    chk("err_count", err, v.eerr);
    chk("first_err", first, v.efirst);
    chk("sat_done", s_done, 1);
    chk("sat_err", s_err, 7);
    chk("sat_first", s_first, 0);
    chk("sat_pass", s_pass, 0);
    tick();
    chk("done_hold", done, 1);
  endtask

  run_vec_t clean;

  initial begin
    runs[0] = '{1'b0, 1'b0, 4'd0, 4'd0, 8'h00, 8'd0, 4'd0, 1'b1};
    runs[1] = '{1'b0, 1'b1, 4'd5, 4'd5, 8'h01, 8'd1, 4'd5, 1'b0};
    runs[2] = '{1'b1, 1'b1, 4'd15, 4'd15, 8'h80, 8'd1, 4'd15, 1'b0};
    runs[3] = '{1'b0, 1'b1, 4'd3, 4'd12, 8'h10, 8'd2, 4'd3, 1'b0};
    clean = runs[0];

    #3;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_we", we, 0);
    chk("rst_acc_rst", acc_rst, 0);
    chk("rst_err", err, 0);
    chk("rst_first", first, 0);
    #9 rst_n = 1'b1;
    tick();
    chk("idle_busy", busy, 0);

    for (int i = 0; i < 4; i++) run(runs[i]);

    // Abort mid-read with address 5 corrupted.
    corrupt_en = 1'b1;
    corrupt_a1 = 4'd5;
    corrupt_a2 = 4'd5;
    corrupt_mask = 8'h01;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    for (int k = 0; k < 16; k++) tick();
    for (int k = 0; k < 7; k++) tick();
    chk("ab_addr", mem_addr, 7);
    chk("ab_re_pre", re, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("ab_re", re, 0);
    chk("ab_busy", busy, 0);
    chk("ab_done", done, 0);
    chk("ab_err_hold", err, 1);
    chk("ab_first_hold", first, 5);
    tick();
    chk("ab_idle", busy, 0);

    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("sa_busy", busy, 0);
    chk("sa_accrst", acc_rst, 0);

    run(clean);

    // Reset asserted mid-write at address 9.
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    for (int k = 0; k < 9; k++) tick();
    chk("rw_addr", mem_addr, 9);
    chk("rw_we_pre", we, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_we", we, 0);
    chk("ar_acc_en", acc_en, 0);
    chk("ar_busy", busy, 0);
    chk("ar_wdata", wdata, 0);
    chk("ar_addr", mem_addr, 0);
    chk("ar_done", done, 0);
    chk("ar_err", err, 0);
    tick();
    #2 rst_n = 1'b1;
    tick();
    chk("ar_idle_busy", busy, 0);
    chk("ar_idle_done", done, 0);
    chk("ar_idle_accrst", acc_rst, 0);

    run(clean);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
